// File: rtl/switch_pkg.sv
// Shared types and width helpers for the switch-bank puzzle.
package switch_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } state_t;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int unsigned step_w(input int unsigned n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

  // Width able to hold the values 0..n inclusive.
  function automatic int unsigned strike_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int unsigned num_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  // LSB position of target k in the flattened pattern table.
  function automatic int unsigned tgt_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Synchronises and debounces the switch bank; pulses move once per stable change.
module sw_debounce #(
  parameter int unsigned W          = 8,
  parameter int unsigned DEB_CYCLES = 200
) (
  input  logic         Clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] swline,
  output logic [W-1:0] committed,
  output logic         move
);

  localparam int unsigned CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [W-1:0]     s1;
  logic [W-1:0]     s2;
  logic [W-1:0]     cand;
  logic [CNT_W-1:0] cnt;
  logic             clr_c;

  // A bounce, or sitting on the committed value, restarts the stability count.
  assign clr_c = (s2 != cand) || (s2 == committed);

  always_ff @(posedge Clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      cand      <= '0;
      cnt       <= '0;
      committed <= '0;
      move      <= 1'b0;
    end else begin
      s1   <= swline;
      s2   <= s1;
      cand <= s2;
      move <= 1'b0;
      if (load) begin
        committed <= s2;
        cnt       <= '0;
      end else if (clr_c) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        move      <= 1'b1;
        committed <= s2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_seq_puzzle.sv
// Switch-bank sequence puzzle: judges each debounced move against the current target.
module switch_seq_puzzle
  import switch_pkg::*;
#(
  parameter int unsigned W           = 8,
  parameter int unsigned STEPS       = 4,
  parameter int unsigned DEB_CYCLES  = 200,
  parameter int unsigned MAX_STRIKES = 3
) (
  input  logic                            Clk,
  input  logic                            rst,
  input  logic                            arm,
  input  logic [STEPS*W-1:0]              exp_seq,
  input  logic [num_w(STEPS)-1:0]         num_steps,
  input  logic [W-1:0]                    swline,
  output logic [step_w(STEPS)-1:0]        step_idx,
  output logic [strike_w(MAX_STRIKES)-1:0] strikes,
  output logic                            strike_p,
  output logic                            busy,
  output logic                            boom,
  output logic                            done
);

  localparam int unsigned STEP_W = step_w(STEPS);
  localparam int unsigned STRK_W = strike_w(MAX_STRIKES);
  localparam int unsigned NUM_W  = num_w(STEPS);

  state_t              state;
  state_t              state_nxt;
  logic [STEPS*W-1:0]  exp_q;
  logic [STEP_W-1:0]   last_q;
  logic [W-1:0]        committed;
  logic                move;

  logic [STEP_W-1:0]   step_nxt;
  logic [STRK_W-1:0]   strikes_nxt;
  logic                strike_nxt;
  logic                boom_nxt;
  logic                done_nxt;
  logic                busy_nxt;

  logic                load_c;
  logic [NUM_W-1:0]    len_c;
  logic [W-1:0]        target_c;
  logic                hit_c;
  logic                last_c;
  logic [STRK_W-1:0]   strike_inc_c;
  logic                max_c;

  sw_debounce #(
    .W          (W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .Clk       (Clk),
    .rst       (rst),
    .load      (load_c),
    .swline    (swline),
    .committed (committed),
    .move      (move)
  );

  assign load_c       = (state == IDLE) && arm;
  assign target_c     = exp_q[tgt_lsb(32'(step_idx), W) +: W];
  assign hit_c        = (committed == target_c);
  assign last_c       = (step_idx == last_q);
  assign strike_inc_c = strikes + STRK_W'(1);
  assign max_c        = (strike_inc_c == STRK_W'(MAX_STRIKES));

  // Sequence length clamped into 1..STEPS.
  always_comb begin
    len_c = num_steps;
    if (num_steps == '0) begin
      len_c = NUM_W'(1);
    end else if (num_steps > NUM_W'(STEPS)) begin
      len_c = NUM_W'(STEPS);
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      exp_q  <= '0;
      last_q <= '0;
    end else if (load_c) begin
      exp_q  <= exp_seq;
      last_q <= STEP_W'(len_c - NUM_W'(1));
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state    <= IDLE;
      step_idx <= '0;
      strikes  <= '0;
      strike_p <= 1'b0;
      busy     <= 1'b0;
      boom     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_idx <= step_nxt;
      strikes  <= strikes_nxt;
      strike_p <= strike_nxt;
      busy     <= busy_nxt;
      boom     <= boom_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arm) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (move) begin
          if (hit_c && last_c)      state_nxt = DEFUSED;
          else if (!hit_c && max_c) state_nxt = EXPLODED;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    step_nxt    = step_idx;
    strikes_nxt = strikes;
    strike_nxt  = 1'b0;
    boom_nxt    = boom;
    done_nxt    = done;
    busy_nxt    = (state_nxt == ACTIVE);
    if (load_c) begin
      step_nxt    = '0;
      strikes_nxt = '0;
    end else if ((state == ACTIVE) && move) begin
      if (hit_c) begin
        if (last_c) done_nxt = 1'b1;
        else        step_nxt = step_idx + STEP_W'(1);
      end else begin
        strike_nxt  = 1'b1;
        strikes_nxt = strike_inc_c;
        if (max_c) boom_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_seq_puzzle.sv
// Directed bench for switch_seq_puzzle with a short debounce window.
module tb_switch_seq_puzzle;

  localparam int unsigned W           = 8;
  localparam int unsigned STEPS       = 4;
  localparam int unsigned DEB_CYCLES  = 4;
  localparam int unsigned MAX_STRIKES = 3;

  logic              Clk;
  logic              rst;
  logic              arm;
  logic [STEPS*W-1:0] exp_seq;
  logic [2:0]        num_steps;
  logic [W-1:0]      swline;
  logic [1:0]        step_idx;
  logic [1:0]        strikes;
  logic              strike_p;
  logic              busy;
  logic              boom;
  logic              done;

  int total = 0;
  int bad   = 0;
  int mv_cnt = 0;
  int sp_cnt = 0;

  switch_seq_puzzle #(
    .W           (W),
    .STEPS       (STEPS),
    .DEB_CYCLES  (DEB_CYCLES),
    .MAX_STRIKES (MAX_STRIKES)
  ) dut (
    .Clk       (Clk),
    .rst       (rst),
    .arm       (arm),
    .exp_seq   (exp_seq),
    .num_steps (num_steps),
    .swline    (swline),
    .step_idx  (step_idx),
    .strikes   (strikes),
    .strike_p  (strike_p),
    .busy      (busy),
    .boom      (boom),
    .done      (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (dut.u_deb.move === 1'b1) mv_cnt++;
    if (strike_p === 1'b1) sp_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic arm_puzzle(input logic [2:0] ns, input logic [31:0] seq);
    exp_seq   = seq;
    num_steps = ns;
    arm       = 1'b1;
    tick(1);
    arm       = 1'b0;
  endtask

  task automatic hold_sw(input logic [7:0] v, input int n);
    swline = v;
    tick(n);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; exp_seq = '0; num_steps = '0; swline = '0;
    tick(3);
    rst = 1'b0;
    chk("rst_step", 32'(step_idx), 0);
    chk("rst_strikes", 32'(strikes), 0);
    chk("rst_strike_p", 32'(strike_p), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_boom", 32'(boom), 0);
    chk("rst_done", 32'(done), 0);

    // 1: happy path, two steps
    arm_puzzle(3'd2, 32'h0000_474F);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_step0", 32'(step_idx), 0);
    hold_sw(8'h4F, 8);
    chk("t1_step1", 32'(step_idx), 1);
    chk("t1_done_early", 32'(done), 0);
    hold_sw(8'h47, 8);
    chk("t1_done", 32'(done), 1);
    chk("t1_boom", 32'(boom), 0);
    chk("t1_strikes", 32'(strikes), 0);
    chk("t1_busy_off", 32'(busy), 0);

    // 2: bouncing never commits; a clean hold commits once
    do_reset();
    swline = 8'h00;
    tick(3);
    arm_puzzle(3'd2, 32'h0000_0001);
    mv_cnt = 0; sp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      hold_sw(8'h01, 2);
      hold_sw(8'h00, 2);
    end
    hold_sw(8'h00, 8);
    chk("t2_bounce_moves", 32'(mv_cnt), 0);
    chk("t2_bounce_strikes", 32'(sp_cnt), 0);
    chk("t2_bounce_step", 32'(step_idx), 0);
    swline = 8'h01;
    tick(6);
    chk("t2_move_e6", 32'(dut.u_deb.move), 0);
    tick(1);
    chk("t2_move_e7", 32'(dut.u_deb.move), 1);
    tick(1);
    chk("t2_move_e8", 32'(dut.u_deb.move), 0);
    chk("t2_step", 32'(step_idx), 1);
    chk("t2_move_count", 32'(mv_cnt), 1);
    chk("t2_strikes", 32'(strikes), 0);

    // 3: three wrong moves explode
    do_reset();
    swline = 8'h00;
    tick(3);
    arm_puzzle(3'd1, 32'h0000_000F);
    sp_cnt = 0;
    hold_sw(8'h01, 8);
    chk("t3_strike_p1", 32'(strike_p), 1);
    chk("t3_strikes1", 32'(strikes), 1);
    chk("t3_boom1", 32'(boom), 0);
    hold_sw(8'h00, 8);
    chk("t3_strikes2", 32'(strikes), 2);
    chk("t3_done2", 32'(done), 0);
    hold_sw(8'h02, 8);
    chk("t3_strikes3", 32'(strikes), 3);
    chk("t3_boom3", 32'(boom), 1);
    chk("t3_busy3", 32'(busy), 0);
    tick(1);
    chk("t3_pulses", 32'(sp_cnt), 3);
    chk("t3_pulse_low", 32'(strike_p), 0);
    hold_sw(8'h0F, 8);
    chk("t3_done_never", 32'(done), 0);
    chk("t3_boom_sticky", 32'(boom), 1);

    // 4: recover after one strike; arm ignored while active or defused
    do_reset();
    swline = 8'h00;
    tick(3);
    arm_puzzle(3'd2, 32'h0000_474F);
    hold_sw(8'h01, 8);
    chk("t4_strike", 32'(strikes), 1);
    arm_puzzle(3'd1, 32'h0000_0000);
    chk("t4_arm_ignored", 32'(strikes), 1);
    hold_sw(8'h4F, 8);
    chk("t4_step1", 32'(step_idx), 1);
    hold_sw(8'h47, 8);
    chk("t4_done", 32'(done), 1);
    chk("t4_boom", 32'(boom), 0);
    chk("t4_strikes", 32'(strikes), 1);
    arm_puzzle(3'd2, 32'h0000_474F);
    chk("t4_rearm_busy", 32'(busy), 0);
    chk("t4_rearm_done", 32'(done), 1);

    // 5: num_steps=0 clamps to 1; arm baseline makes no move
    do_reset();
    swline = 8'h4F;
    tick(4);
    arm_puzzle(3'd0, 32'hAAAA_AA4F);
    sp_cnt = 0;
    tick(8);
    chk("t5_no_strike", 32'(sp_cnt), 0);
    chk("t5_no_done", 32'(done), 0);
    chk("t5_busy", 32'(busy), 1);
    hold_sw(8'h00, 8);
    chk("t5_strike", 32'(strikes), 1);
    hold_sw(8'h4F, 8);
    chk("t5_done", 32'(done), 1);

    // 5b: num_steps above STEPS clamps to STEPS
    do_reset();
    swline = 8'h00;
    tick(3);
    arm_puzzle(3'd7, 32'h0403_0201);
    hold_sw(8'h01, 8);
    hold_sw(8'h02, 8);
    hold_sw(8'h03, 8);
    chk("t5b_step3", 32'(step_idx), 3);
    chk("t5b_not_done", 32'(done), 0);
    hold_sw(8'h04, 8);
    chk("t5b_done", 32'(done), 1);

    // 6: reset mid-run with a move pending
    do_reset();
    swline = 8'h00;
    tick(3);
    arm_puzzle(3'd2, 32'h0000_474F);
    hold_sw(8'h4F, 8);
    chk("t6_step1", 32'(step_idx), 1);
    swline = 8'h47;
    tick(6);
    rst = 1'b1;
    tick(1);
    chk("t6_step", 32'(step_idx), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_strikes", 32'(strikes), 0);
    chk("t6_boom", 32'(boom), 0);
    chk("t6_move", 32'(dut.u_deb.move), 0);
    rst = 1'b0;
    tick(10);
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_idle_done", 32'(done), 0);
    arm_puzzle(3'd1, 32'h0000_0000);
    chk("t6_rearm_busy", 32'(busy), 1);
    hold_sw(8'h00, 8);
    chk("t6_rearm_done", 32'(done), 1);
    chk("t6_rearm_strikes", 32'(strikes), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
